// File: rtl/open_avr_mem_pkg.sv
// Shared definitions for the data-memory front-end: default SRAM window,
// data-space address width, requester port ids and the window decode helper.
package open_avr_mem_pkg;

  localparam int unsigned  DATA_ADDR_W       = 16;
  localparam int unsigned  RAM_WIDTH_DEFAULT = 9;
  localparam logic [15:0]  RAM_BASE_DEFAULT  = 16'h0060;

  // Requester identity, also used to tag the in-flight response
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  // True when addr lands inside [base, base + 2**width); the subtraction is done
  // one bit wider than the address so an address below base can never wrap into range
  function automatic logic in_window(input logic [DATA_ADDR_W-1:0] addr,
                                     input logic [DATA_ADDR_W-1:0] base,
                                     input int unsigned            width);
    logic [DATA_ADDR_W:0] off;
    logic [DATA_ADDR_W:0] span;
    off  = {1'b0, addr} - {1'b0, base};
    span = {{DATA_ADDR_W{1'b0}}, 1'b1} << width;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter with a lock that lets requester A keep the port
// across a read-modify-write. Holds the round-robin pointer and the lock flag.
import open_avr_mem_pkg::*;

module ram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  output logic [1:0] gnt_o
);

  port_id_e prio_q, prio_d;
  logic     lockHold_q, lockHold_d;
  logic [1:0] gntRaw;

  // State register: pointer starts on A, no lock held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= PORT_A;
      lockHold_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      lockHold_q <= lockHold_d;
    end
  end

  // Next state: pointer moves to the loser of each grant, lock follows A's grants only
  always_comb begin
    prio_d     = prio_q;
    lockHold_d = lockHold_q;
    if (gntRaw[0]) begin
      prio_d     = PORT_B;
      lockHold_d = lock_i;
    end else if (gntRaw[1]) begin
      prio_d     = PORT_A;
    end
  end

  // Grant decode: a held lock shuts B out entirely; grants are suppressed during reset
  always_comb begin
    gntRaw = 2'b00;
    if (lockHold_q) begin
      gntRaw = {1'b0, req_i[0]};
    end else begin
      case (req_i)
        2'b01:   gntRaw = 2'b01;
        2'b10:   gntRaw = 2'b10;
        2'b11:   gntRaw = (prio_q == PORT_A) ? 2'b01 : 2'b10;
        default: gntRaw = 2'b00;
      endcase
    end
    gnt_o = rst_n ? gntRaw : 2'b00;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Front-end of the single-port data SRAM: arbitrates the CPU (A) and debug/DMA (B)
// byte ports, maps data-space addresses onto SRAM offsets, rejects accesses outside
// the window and routes the one-cycle-late read data back to the requesting port.
import open_avr_mem_pkg::*;

module ram_port_arbiter #(
  parameter int unsigned ram_width = RAM_WIDTH_DEFAULT,
  parameter logic [15:0] ram_base  = RAM_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req_i,
  input  logic                 a_we_i,
  input  logic [15:0]          a_addr_i,
  input  logic [7:0]           a_wdata_i,
  input  logic                 a_lock_i,
  output logic                 a_gnt_o,
  output logic                 a_rvalid_o,
  output logic [7:0]           a_rdata_o,
  output logic                 a_err_o,
  input  logic                 b_req_i,
  input  logic                 b_we_i,
  input  logic [15:0]          b_addr_i,
  input  logic [7:0]           b_wdata_i,
  output logic                 b_gnt_o,
  output logic                 b_rvalid_o,
  output logic [7:0]           b_rdata_o,
  output logic                 b_err_o,
  output logic                 ram_re_o,
  output logic                 ram_we_o,
  output logic [ram_width-1:0] ram_addr_o,
  output logic [7:0]           ram_wdata_o,
  input  logic [7:0]           ram_rdata_i
);

  logic [1:0]  gnt;
  logic        granted;
  port_id_e    winner;
  logic        selWe;
  logic [15:0] selAddr;
  logic [7:0]  selWdata;
  logic [16:0] offset;
  logic        inWindow;

  logic        rspValid_q, rspValid_d;
  port_id_e    rspPort_q, rspPort_d;
  logic        rspErr_q, rspErr_d;

  ram_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({b_req_i, a_req_i}),
    .lock_i (a_lock_i),
    .gnt_o  (gnt)
  );

  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];

  // Steer the winning port onto the SRAM and decode its address against the window
  always_comb begin
    granted  = |gnt;
    winner   = gnt[1] ? PORT_B : PORT_A;
    selWe    = (winner == PORT_B) ? b_we_i    : a_we_i;
    selAddr  = (winner == PORT_B) ? b_addr_i  : a_addr_i;
    selWdata = (winner == PORT_B) ? b_wdata_i : a_wdata_i;
    offset   = {1'b0, selAddr} - {1'b0, ram_base};
    inWindow = in_window(selAddr, ram_base, ram_width);
    ram_re_o    = granted && inWindow && !selWe;
    ram_we_o    = granted && inWindow && selWe;
    ram_addr_o  = offset[ram_width-1:0];
    ram_wdata_o = selWdata;
  end

  // Decide whether this grant owes its port a response next cycle; in-window writes do not
  always_comb begin
    rspValid_d = granted && (!inWindow || !selWe);
    rspPort_d  = winner;
    rspErr_d   = !inWindow;
  end

  // One-deep response tag; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_q <= 1'b0;
      rspPort_q  <= PORT_A;
      rspErr_q   <= 1'b0;
    end else begin
      rspValid_q <= rspValid_d;
      rspPort_q  <= rspPort_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Return SRAM data (or a zero error reply) to whichever port was granted last cycle
  always_comb begin
    a_rvalid_o = rspValid_q && (rspPort_q == PORT_A);
    b_rvalid_o = rspValid_q && (rspPort_q == PORT_B);
    a_err_o    = a_rvalid_o && rspErr_q;
    b_err_o    = b_rvalid_o && rspErr_q;
    a_rdata_o  = (a_rvalid_o && !rspErr_q) ? ram_rdata_i : 8'h00;
    b_rdata_o  = (b_rvalid_o && !rspErr_q) ? ram_rdata_i : 8'h00;
  end

endmodule
